serial_echo_checker: RTL and testbench
======================================

# serial_echo_checker

Host-side counterpart of the board's serial echo loopback: drives the existing async_transmitter with an incrementing byte stream, receives the reply through the existing async_receiver, and checks that each reply equals the sent byte plus one (mod 256). It counts passes, mismatches and timeouts for link bring-up and soak testing. It sits between one transmitter/receiver pair, and its byte-level ports connect directly to those instances.

## Interface

- ClkFrequency, 24000000: system clock in Hz, for documentation and default derivation only.
- TimeoutCycles, ClkFrequency/100: cycles to wait for an echo after TxD_start; the default is 10 ms. Minimum 2.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- TxD_start  out  1  one-cycle send strobe to the transmitter.
- TxD_data  out  8  byte to send; valid while TxD_start=1, held until the next send.
- TxD_busy  in  1  transmitter busy; high while a frame is shifting out.
- RxD_data_ready  in  1  one-cycle strobe from the receiver; a byte is available.
- RxD_data  in  8  received byte; valid when RxD_data_ready=1.
- pass_count  out  16  echoes matching expected; saturates at 0xFFFF.
- err_count  out  16  echoes not matching; saturates at 0xFFFF.
- timeout_count  out  16  transactions with no echo in time; saturates at 0xFFFF.
- last_err_data  out  8  received byte of the most recent mismatch.
- LED  out  2  LED[0] sticky error (err or timeout seen since reset); LED[1] toggles on every pass.

## Operation

- Reset values: TxD_start=0, TxD_data=0x00, all counts=0, last_err_data=0x00, LED=2'b00, internal seq=0x00, state IDLE, timer=0.
- The FSM has three states: IDLE, SEND and WAIT_ECHO.
- IDLE: moves to SEND when enable=1 and TxD_busy=0. Otherwise it stays in IDLE.
- SEND, one cycle:
  - TxD_start=1 and TxD_data=seq.
  - Timer cleared to 0.
  - Next state is WAIT_ECHO.
- WAIT_ECHO: the timer increments each cycle.
  - RxD_data_ready=1 with RxD_data==seq+1 (8-bit wrap, so 0xFF expects 0x00): pass_count++ and LED[1] toggles.
  - RxD_data_ready=1 with any other value: err_count++, last_err_data<=RxD_data, LED[0]<=1.
  - No ready while timer==TimeoutCycles-1: timeout_count++ and LED[0]<=1.
  - On any of these three outcomes: seq<=seq+1 (wraps 0xFF->0x00) and the next state is IDLE.
- Ready and timeout terminal in the same cycle: ready wins and is judged as pass or error. No timeout is counted.
- RxD_data_ready in IDLE or SEND: ignored. No counter or seq change.
- enable deasserted during SEND or WAIT_ECHO: the current transaction completes normally, then the FSM stays in IDLE.
- Counters saturate. They never wrap.
- Reset asserted mid-transaction: every output returns to its reset value immediately, including TxD_start=0. After release, operation restarts at seq=0x00.

## Timing

- TxD_start is registered and is exactly one cycle wide. It is never asserted while TxD_busy=1 was sampled in the preceding IDLE cycle.
- Sequence timing:
  - IDLE (enable=1, TxD_busy=0) at edge N: TxD_start=1 during cycle N+1.
  - WAIT_ECHO from N+2.
- Echo handling:
  - Echo ready sampled at edge M: counters and last_err_data update at M+1, FSM back in IDLE at M+1.
  - Earliest next TxD_start is the cycle after M+1, provided TxD_busy=0 and enable=1.
- Timeout fires TimeoutCycles cycles after the SEND cycle. Counters update on that edge.
- Throughput is one transaction at a time. No pipelining, and there is never more than one outstanding byte.

## Test plan

- Bench settings: TimeoutCycles=100. The bench echo model returns byte+1 30 cycles after TxD_start; TxD_busy is high for 10 cycles after each start. Enable for 5 transactions -> TxD_data sequence 0x00..0x04, pass_count=5, err_count=0, timeout_count=0, LED=2'b10.
- Wrap: run 256 transactions, with the 256th sending 0xFF -> its echo 0x00 counts as a pass. pass_count=256, next TxD_data=0x00.
- Mismatch: model returns 0x55 for the first byte (0x00) -> err_count=1, last_err_data=0x55, LED[0]=1, seq advances to 0x01.
- No echo: model silent -> timeout_count=1 exactly 100 cycles after the TxD_start cycle, next TxD_start carries 0x01. A stray RxD_data_ready pulse in IDLE changes nothing.
- Race: echo ready asserted on the timeout terminal cycle with the correct value -> pass_count=1, timeout_count=0.
- Control and reset:
  - Drop enable mid-WAIT_ECHO -> the transaction completes and no further TxD_start occurs.
  - Assert reset mid-WAIT_ECHO -> all outputs read zero immediately. After release with enable=1, the first TxD_data=0x00.

Source files
------------

// File: rtl/serial_echo_checker.sv
// serial_echo_checker
//   Loopback soak tester for a UART link whose far end echoes every byte
//   back incremented by one. It sends an incrementing byte stream, one
//   byte at a time, and judges each reply. A reply is a pass when it equals
//   the sent byte plus one, modulo 256. Any other reply is an error. No
//   reply within TimeoutCycles is a timeout.
//
// Parameters
//   ClkFrequency   system clock in Hz; only used to derive the default timeout
//   TimeoutCycles  cycles to wait for an echo after the send strobe (>= 2)
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   enable            level run request
//   TxD_start/_data   one-cycle send strobe and held byte to async_transmitter
//   TxD_busy          transmitter busy
//   RxD_data_ready    one-cycle strobe from async_receiver with RxD_data
//   pass_count        matching echoes       (saturating)
//   err_count         mismatching echoes    (saturating)
//   timeout_count     echoes never seen     (saturating)
//   last_err_data     received byte of the latest mismatch
//   LED[0]            sticky: any error or timeout since reset
//   LED[1]            toggles on every pass
module serial_echo_checker #(
    parameter int ClkFrequency  = 24000000,
    parameter int TimeoutCycles = ClkFrequency / 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    input  logic        TxD_busy,
    input  logic        RxD_data_ready,
    input  logic [7:0]  RxD_data,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count,
    output logic [7:0]  last_err_data,
    output logic [1:0]  LED
);

    // The timer only has to reach TimeoutCycles-1.
    localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ECHO = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    seq;
    logic [TW-1:0] timer;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            seq           <= 8'h00;
            timer         <= '0;
            TxD_start     <= 1'b0;
            TxD_data      <= 8'h00;
            pass_count    <= 16'h0000;
            err_count     <= 16'h0000;
            timeout_count <= 16'h0000;
            last_err_data <= 8'h00;
            LED           <= 2'b00;
        end else begin
            // Send strobe is a single-cycle pulse; only IDLE raises it.
            TxD_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !TxD_busy) begin
                        TxD_start <= 1'b1;
                        TxD_data  <= seq;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT_ECHO;
                end
                WAIT_ECHO: begin
                    timer <= timer + TW'(1);
                    // A reply on the terminal cycle still counts as a reply.
                    if (RxD_data_ready) begin
                        if (RxD_data == 8'(seq + 8'd1)) begin
                            pass_count <= sat_inc(pass_count);
                            LED[1]     <= ~LED[1];
                        end else begin
                            err_count     <= sat_inc(err_count);
                            last_err_data <= RxD_data;
                            LED[0]        <= 1'b1;
                        end
                        seq   <= seq + 8'd1;
                        state <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_count <= sat_inc(timeout_count);
                        LED[0]        <= 1'b1;
                        seq           <= seq + 8'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_echo_checker.sv
// Bench for serial_echo_checker. A far-end echo responder reacts to the
// send strobe. A transaction-level model predicts every output on every
// cycle, and literal checks pin the model at the end of each scenario.
module tb_serial_echo_checker;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        TxD_busy = 1'b0;
    logic        RxD_data_ready = 1'b0;
    logic [7:0]  RxD_data = 8'h00;
    logic        TxD_start;
    logic [7:0]  TxD_data;
    logic [15:0] pass_count, err_count, timeout_count;
    logic [7:0]  last_err_data;
    logic [1:0]  LED;

    serial_echo_checker #(.ClkFrequency(24000000), .TimeoutCycles(T)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .TxD_start(TxD_start), .TxD_data(TxD_data), .TxD_busy(TxD_busy),
        .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
        .pass_count(pass_count), .err_count(err_count),
        .timeout_count(timeout_count), .last_err_data(last_err_data), .LED(LED)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- far-end echo responder ----------------
    typedef enum {M_NORMAL, M_BAD_FIRST, M_SILENT, M_RACE} mode_t;
    mode_t      mode = M_NORMAL;
    int         n_starts = 0;
    int         st = -1000;
    logic       pend = 1'b0;
    logic [7:0] sbyte = 8'h00;
    int         stray_req = 0;
    int         stray_done = 0;

    initial forever begin
        @(posedge clk);
        #1;
        RxD_data_ready = 1'b0;
        if (reset) begin
            pend = 1'b0;
            st   = -1000;
        end else if (TxD_start) begin
            st    = cyc;
            sbyte = TxD_data;
            pend  = 1'b1;
            n_starts++;
        end
        TxD_busy = (cyc > st) && (cyc <= st + 10);
        if (pend && mode != M_SILENT && cyc == st + ((mode == M_RACE) ? T : 30)) begin
            RxD_data_ready = 1'b1;
            RxD_data = (mode == M_BAD_FIRST && sbyte == 8'h00) ? 8'h55 : sbyte + 8'd1;
            pend = 1'b0;
        end else if (stray_req != stray_done) begin
            RxD_data_ready = 1'b1;
            RxD_data = 8'h77;
            stray_done++;
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    logic        m_out = 1'b0;   // a byte is outstanding (from send strobe to judgement)
    int          m_s = 0;        // cycle of the send strobe
    logic        m_start = 1'b0;
    logic [7:0]  m_seq = 8'h00, m_data = 8'h00, m_last = 8'h00;
    logic [15:0] m_pass = 0, m_err = 0, m_to = 0;
    logic [1:0]  m_led = 2'b00;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("rst_start", {31'd0, TxD_start}, 0);
            chk("rst_data", {24'd0, TxD_data}, 0);
            chk("rst_pass", {16'd0, pass_count}, 0);
            chk("rst_err", {16'd0, err_count}, 0);
            chk("rst_to", {16'd0, timeout_count}, 0);
            chk("rst_last", {24'd0, last_err_data}, 0);
            chk("rst_led", {30'd0, LED}, 0);
            m_out = 0; m_start = 0; m_seq = 0; m_data = 0; m_last = 0;
            m_pass = 0; m_err = 0; m_to = 0; m_led = 0;
        end else begin
            chk("start", {31'd0, TxD_start}, {31'd0, m_start});
            chk("data", {24'd0, TxD_data}, {24'd0, m_data});
            chk("pass", {16'd0, pass_count}, {16'd0, m_pass});
            chk("err", {16'd0, err_count}, {16'd0, m_err});
            chk("timeout", {16'd0, timeout_count}, {16'd0, m_to});
            chk("last_err", {24'd0, last_err_data}, {24'd0, m_last});
            chk("led", {30'd0, LED}, {30'd0, m_led});
            m_start = 1'b0;
            if (m_out && cyc > m_s) begin
                if (RxD_data_ready) begin
                    if (RxD_data == m_seq + 8'd1) begin
                        if (m_pass != 16'hFFFF) m_pass++;
                        m_led[1] = ~m_led[1];
                    end else begin
                        if (m_err != 16'hFFFF) m_err++;
                        m_last = RxD_data;
                        m_led[0] = 1'b1;
                    end
                    m_seq++;
                    m_out = 1'b0;
                end else if (cyc == m_s + T) begin
                    if (m_to != 16'hFFFF) m_to++;
                    m_led[0] = 1'b1;
                    m_seq++;
                    m_out = 1'b0;
                end
            end else if (!m_out && enable && !TxD_busy) begin
                m_out   = 1'b1;
                m_s     = cyc + 1;
                m_start = 1'b1;
                m_data  = m_seq;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_en(input logic v);
        @(posedge clk);
        #1 enable = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        cycles(2);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k;
        k = 0;
        while (n_starts < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", {31'd0, n_starts >= target}, 1);
    endtask

    int base;
    int s0;

    initial begin
        // Reset values, checked while reset is still held.
        cycles(2);
        chk("lit_rst_pass", {16'd0, pass_count}, 0);
        chk("lit_rst_led", {30'd0, LED}, 0);
        chk("lit_rst_data", {24'd0, TxD_data}, 0);

        // Five clean transactions, then enable dropped mid-wait.
        do_reset();
        mode = M_NORMAL;
        base = n_starts;
        set_en(1'b1);
        wait_starts(base + 5, 400);
        cycles(15);
        set_en(1'b0);
        cycles(60);
        chk("lit5_pass", {16'd0, pass_count}, 5);
        chk("lit5_err", {16'd0, err_count}, 0);
        chk("lit5_to", {16'd0, timeout_count}, 0);
        chk("lit5_led", {30'd0, LED}, 32'h2);
        chk("lit5_data", {24'd0, TxD_data}, 32'h04);
        chk("lit5_nostart", n_starts - base, 5);

        // 256 transactions: byte 0xFF echoed as 0x00 is a pass.
        do_reset();
        base = n_starts;
        set_en(1'b1);
        wait_starts(base + 256, 256 * 40);
        chk("litw_data_ff", {24'd0, TxD_data}, 32'hFF);
        cycles(15);
        set_en(1'b0);
        cycles(40);
        chk("litw_pass", {16'd0, pass_count}, 256);
        chk("litw_err", {16'd0, err_count}, 0);
        set_en(1'b1);
        wait_starts(base + 257, 100);
        chk("litw_data_wrap", {24'd0, TxD_data}, 32'h00);
        cycles(15);
        set_en(1'b0);
        cycles(40);

        // Mismatch on the first byte.
        do_reset();
        mode = M_BAD_FIRST;
        base = n_starts;
        set_en(1'b1);
        wait_starts(base + 1, 50);
        cycles(15);
        set_en(1'b0);
        cycles(40);
        chk("litm_err", {16'd0, err_count}, 1);
        chk("litm_last", {24'd0, last_err_data}, 32'h55);
        chk("litm_led", {30'd0, LED}, 32'h1);
        chk("litm_pass", {16'd0, pass_count}, 0);
        set_en(1'b1);
        wait_starts(base + 2, 50);
        chk("litm_next", {24'd0, TxD_data}, 32'h01);
        cycles(15);
        set_en(1'b0);
        cycles(40);
        chk("litm_pass2", {16'd0, pass_count}, 1);

        // Silent far end: timeout lands exactly T cycles after the send cycle.
        do_reset();
        mode = M_SILENT;
        base = n_starts;
        set_en(1'b1);
        wait_starts(base + 1, 50);
        s0 = cyc;
        cycles(15);
        set_en(1'b0);
        while (cyc < s0 + T) @(negedge clk);
        chk("lits_to_before", {16'd0, timeout_count}, 0);
        @(negedge clk);
        chk("lits_to_at", {16'd0, timeout_count}, 1);
        chk("lits_led", {30'd0, LED}, 32'h1);
        cycles(3);
        @(posedge clk);
        #1 stray_req++;
        cycles(4);
        chk("lits_stray_pass", {16'd0, pass_count}, 0);
        chk("lits_stray_err", {16'd0, err_count}, 0);
        chk("lits_stray_to", {16'd0, timeout_count}, 1);
        set_en(1'b1);
        wait_starts(base + 2, 50);
        chk("lits_next", {24'd0, TxD_data}, 32'h01);
        cycles(5);
        set_en(1'b0);
        cycles(T + 10);
        chk("lits_to2", {16'd0, timeout_count}, 2);

        // Echo arrives on the timeout terminal cycle.
        do_reset();
        mode = M_RACE;
        base = n_starts;
        set_en(1'b1);
        wait_starts(base + 1, 50);
        cycles(15);
        set_en(1'b0);
        cycles(T + 20);
        chk("litr_pass", {16'd0, pass_count}, 1);
        chk("litr_to", {16'd0, timeout_count}, 0);

        // Reset in the middle of a wait.
        do_reset();
        mode = M_NORMAL;
        base = n_starts;
        set_en(1'b1);
        wait_starts(base + 4, 300);
        cycles(10);
        chk("litx_pre_pass", {16'd0, pass_count}, 3);
        chk("litx_pre_data", {24'd0, TxD_data}, 32'h03);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("litx_start", {31'd0, TxD_start}, 0);
        chk("litx_data", {24'd0, TxD_data}, 0);
        chk("litx_pass", {16'd0, pass_count}, 0);
        chk("litx_led", {30'd0, LED}, 0);
        cycles(2);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_starts(base + 5, 50);
        chk("litx_first", {24'd0, TxD_data}, 32'h00);
        cycles(15);
        set_en(1'b0);
        cycles(40);
        chk("litx_pass_after", {16'd0, pass_count}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
